// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host blocks: FSM encoding, default timing
// constants and line-filter patterns.
package ps2_pkg;

   localparam int unsigned INHIBIT_CYCLES_DEF = 5000;     // 100 us at 50 MHz
   localparam int unsigned RTS_CYCLES_DEF     = 50;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;

   localparam logic [7:0] HIST_RESET = 8'hFF;
   localparam logic [7:0] HIST_FALL  = 8'hF0;
   localparam logic [7:0] HIST_HIGH  = 8'hFF;
   localparam logic [7:0] HIST_LOW   = 8'h00;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      INHIBIT,
      RTS,
      DATA,
      ACK,
      WAIT_IDLE
   } tx_state_t;

   // Width of a counter that runs 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Glitch filter and falling-edge detector for the PS/2 clock and data lines.
// Shared by the transmitter and the receiver.
module ps2_line_filter
   import ps2_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clk_line,
   input  logic d_line,
   output logic clk_fall,
   output logic clk_high,
   output logic d_high,
   output logic d_level
);

   logic [7:0] clk_hist;
   logic [7:0] d_hist;
   logic       d_level_q;

   // The history registers also act as the synchroniser for the async lines.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_hist  <= HIST_RESET;
         d_hist    <= HIST_RESET;
         d_level_q <= 1'b1;
      end else begin
         clk_hist <= {clk_hist[6:0], clk_line};
         d_hist   <= {d_hist[6:0], d_line};
         if (d_hist == HIST_HIGH)
            d_level_q <= 1'b1;
         else if (d_hist == HIST_LOW)
            d_level_q <= 1'b0;
      end
   end

   assign clk_fall = (clk_hist == HIST_FALL);
   assign clk_high = (clk_hist == HIST_HIGH);
   assign d_high   = (d_hist == HIST_HIGH);
   // Data level with hysteresis: only a fully settled history flips it.
   assign d_level  = (d_hist == HIST_HIGH) ? 1'b1 :
                     (d_hist == HIST_LOW)  ? 1'b0 : d_level_q;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: pulls one command byte from a FIFO,
// performs the inhibit / request-to-send handshake and clocks the frame out.
module ps2_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
   parameter int unsigned RTS_CYCLES     = RTS_CYCLES_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   output logic       rd_en_out,
   input  logic [7:0] rd_d_in,
   input  logic       rd_empty_in,
   input  logic       ps2_clk_in,
   input  logic       ps2_d_in,
   output logic       ps2_clk_oe_out,
   output logic       ps2_d_oe_out,
   output logic       ps2_tx_act_out,
   output logic       ack_out,
   output logic       err_out
);

   localparam int INH_W = cnt_width(INHIBIT_CYCLES);
   localparam int RTS_W = cnt_width(RTS_CYCLES);
   localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);

   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [RTS_W-1:0] RTS_LAST = RTS_W'(RTS_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   tx_state_t        state, state_n;
   logic [7:0]       tx_byte, tx_byte_n;
   logic             parity, parity_n;
   logic [INH_W-1:0] inh_cnt, inh_cnt_n;
   logic [RTS_W-1:0] rts_cnt, rts_cnt_n;
   logic [TO_W-1:0]  to_cnt, to_cnt_n;
   logic [3:0]       bit_idx, bit_idx_n;
   logic             d_oe, d_oe_n;
   logic             ack_q, ack_n;
   logic             err_q, err_n;
   logic             rd_en;

   logic clk_fall, clk_high, d_high, d_level;
   logic timed_out;

   ps2_line_filter u_filter (
      .clk      (clk),
      .rst      (rst),
      .clk_line (ps2_clk_in),
      .d_line   (ps2_d_in),
      .clk_fall (clk_fall),
      .clk_high (clk_high),
      .d_high   (d_high),
      .d_level  (d_level)
   );

   assign timed_out = (to_cnt == TO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tx_byte <= '0;
         parity  <= 1'b0;
         inh_cnt <= '0;
         rts_cnt <= '0;
         to_cnt  <= '0;
         bit_idx <= '0;
         d_oe    <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         tx_byte <= tx_byte_n;
         parity  <= parity_n;
         inh_cnt <= inh_cnt_n;
         rts_cnt <= rts_cnt_n;
         to_cnt  <= to_cnt_n;
         bit_idx <= bit_idx_n;
         d_oe    <= d_oe_n;
         ack_q   <= ack_n;
         err_q   <= err_n;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_n   = state;
      tx_byte_n = tx_byte;
      parity_n  = parity;
      inh_cnt_n = inh_cnt;
      rts_cnt_n = rts_cnt;
      to_cnt_n  = to_cnt;
      bit_idx_n = bit_idx;
      d_oe_n    = d_oe;
      ack_n     = 1'b0;
      err_n     = 1'b0;
      rd_en     = 1'b0;

      case (state)
         IDLE: begin
            if (!rd_empty_in && !rst) begin
               rd_en   = 1'b1;
               state_n = FETCH;
            end
         end
         FETCH: state_n = LATCH;
         LATCH: begin
            tx_byte_n = rd_d_in;
            parity_n  = ~^rd_d_in;
            inh_cnt_n = '0;
            state_n   = INHIBIT;
         end
         INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
               rts_cnt_n = '0;
               state_n   = RTS;
            end else begin
               inh_cnt_n = inh_cnt + 1'b1;
            end
         end
         RTS: begin
            if (rts_cnt == RTS_LAST) begin
               to_cnt_n  = '0;
               bit_idx_n = '0;
               d_oe_n    = 1'b1;          // keep holding the start bit
               state_n   = DATA;
            end else begin
               rts_cnt_n = rts_cnt + 1'b1;
            end
         end
         DATA, ACK, WAIT_IDLE: begin
            // A timeout wins over any edge seen in the same cycle.
            if (timed_out) begin
               d_oe_n  = 1'b0;
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               to_cnt_n = to_cnt + 1'b1;
               if (state == DATA && clk_fall) begin
                  bit_idx_n = bit_idx + 4'd1;
                  if (bit_idx < 4'd8) begin
                     d_oe_n = ~tx_byte[bit_idx[2:0]];
                  end else if (bit_idx == 4'd8) begin
                     d_oe_n = ~parity;
                  end else begin
                     d_oe_n  = 1'b0;
                     state_n = ACK;
                  end
               end else if (state == ACK && clk_fall) begin
                  ack_n   = ~d_level;
                  err_n   = d_level;
                  state_n = WAIT_IDLE;
               end else if (state == WAIT_IDLE && clk_high && d_high) begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Line drivers decode straight from state so reset releases them at once.
   assign rd_en_out      = rd_en;
   assign ps2_clk_oe_out = (state == INHIBIT) || (state == RTS);
   assign ps2_d_oe_out   = (state == RTS) || ((state == DATA) && d_oe);
   assign ps2_tx_act_out = (state != IDLE);
   assign ack_out        = ack_q;
   assign err_out        = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Randomised scoreboard bench for ps2_tx with an open-drain PS/2 device model.
module tb_ps2_tx;

   localparam int INH = 100;
   localparam int RTS = 20;
   localparam int TO  = 2000;
   localparam int H   = 20;               // device half clock period

   localparam int K_ACK = 0;
   localparam int K_ERR = 1;
   localparam int K_TO  = 2;

   localparam int M_ACK    = 0;
   localparam int M_NACK   = 1;
   localparam int M_SILENT = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       rd_en_out;
   logic [7:0] rd_d_in;
   logic       rd_empty_in;
   logic       ps2_clk_in, ps2_d_in;
   logic       ps2_clk_oe_out, ps2_d_oe_out;
   logic       ps2_tx_act_out, ack_out, err_out;

   logic dev_clk_low = 1'b0;
   logic dev_d_low   = 1'b0;
   logic dev_abort   = 1'b0;
   int   dev_mode    = M_ACK;
   int   dev_falls   = 0;

   assign ps2_clk_in = ~(ps2_clk_oe_out | dev_clk_low);
   assign ps2_d_in   = ~(ps2_d_oe_out | dev_d_low);

   always #5 clk = ~clk;

   ps2_tx #(
      .INHIBIT_CYCLES (INH),
      .RTS_CYCLES     (RTS),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rd_en_out      (rd_en_out),
      .rd_d_in        (rd_d_in),
      .rd_empty_in    (rd_empty_in),
      .ps2_clk_in     (ps2_clk_in),
      .ps2_d_in       (ps2_d_in),
      .ps2_clk_oe_out (ps2_clk_oe_out),
      .ps2_d_oe_out   (ps2_d_oe_out),
      .ps2_tx_act_out (ps2_tx_act_out),
      .ack_out        (ack_out),
      .err_out        (err_out)
   );

   typedef struct {
      logic [7:0] data;
      int         kind;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] fifo_q[$];
   logic [9:0] dev_frames[$];
   int         rd_en_cyc[$];
   int         pulse_cyc[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int clk_run  = 0;
   int last_clk_run = 0;
   int rel_cyc  = 0;
   int rd_en_bad = 0;
   int oe_active = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Expected frame as seen on the wire: 8 data bits LSB first, odd parity, stop.
   function automatic logic [9:0] ref_frame(input logic [7:0] b);
      logic [9:0] f;
      int v;
      v = int'(b);
      for (int i = 0; i < 8; i++) f[i] = ((v >> i) % 2) != 0;
      f[8] = ($countones(b) % 2) == 0;
      f[9] = 1'b1;
      return f;
   endfunction

   always @(posedge clk) cyc++;

   // FIFO model: data appears the cycle after a read strobe.
   initial begin
      logic took;
      rd_empty_in = 1'b1;
      rd_d_in     = 8'h00;
      forever begin
         @(negedge clk);
         took = rd_en_out;
         @(posedge clk);
         #1;
         if (took && fifo_q.size() > 0) rd_d_in = fifo_q.pop_front();
         rd_empty_in = (fifo_q.size() == 0);
      end
   end

   task automatic dev_wait(input int n);
      for (int i = 0; i < n && !dev_abort; i++) @(negedge clk);
   endtask

   task automatic run_frame();
      logic [9:0] f;
      f = '0;
      dev_falls = 0;
      dev_wait(10);
      for (int k = 0; k < 10; k++) begin
         dev_clk_low = 1'b1;
         dev_falls++;
         dev_wait(H);
         dev_clk_low = 1'b0;
         dev_wait(H / 2);
         f[k] = ps2_d_in;
         dev_wait(H / 2);
         if (dev_abort) begin
            dev_clk_low = 1'b0;
            dev_d_low   = 1'b0;
            return;
         end
      end
      dev_frames.push_back(f);
      if (dev_mode == M_ACK) dev_d_low = 1'b1;
      dev_wait(10);
      dev_clk_low = 1'b1;
      dev_wait(H);
      dev_clk_low = 1'b0;
      dev_wait(5);
      dev_d_low = 1'b0;
   endtask

   // Device: answers a request-to-send (clock released, data low).
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && ps2_clk_in && !ps2_d_in && dev_mode != M_SILENT && !dev_abort)
            run_frame();
      end
   end

   // Monitor: pops the scoreboard on every ack/err pulse.
   exp_t       mon_e;
   logic [9:0] mon_f, mon_r;
   always @(negedge clk) begin
      if (ps2_clk_oe_out) clk_run++;
      else if (clk_run != 0) begin
         last_clk_run = clk_run;
         clk_run      = 0;
         rel_cyc      = cyc;
      end
      if (rd_en_out) begin
         rd_en_cyc.push_back(cyc);
         if (ps2_tx_act_out) rd_en_bad++;
      end
      if (ps2_clk_oe_out || ps2_d_oe_out) oe_active++;
      if (ack_out || err_out) begin
         pulse_cyc.push_back(cyc);
         check("ack_err_exclusive", ack_out & err_out, 0);
         check("pulse_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("outcome_ack", ack_out, mon_e.kind == K_ACK);
            check("outcome_err", err_out, mon_e.kind != K_ACK);
            if (mon_e.kind == K_TO) begin
               check("timeout_latency", cyc - rel_cyc, TO);
               check("timeout_lines", {ps2_clk_oe_out, ps2_d_oe_out}, 0);
            end else begin
               check("frame_avail", dev_frames.size() != 0, 1);
               if (dev_frames.size() != 0) begin
                  mon_f = dev_frames.pop_front();
                  mon_r = ref_frame(mon_e.data);
                  check("data_bits", mon_f[7:0], mon_r[7:0]);
                  check("parity_bit", mon_f[8], mon_r[8]);
                  check("stop_bit", mon_f[9], mon_r[9]);
               end
            end
         end
      end
   end

   task automatic push_tx(input logic [7:0] b, input int kind);
      exp_t e;
      e.data = b;
      e.kind = kind;
      exp_q.push_back(e);
      fifo_q.push_back(b);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(exp_q.size() == 0 && fifo_q.size() == 0 && rd_empty_in &&
                   !ps2_tx_act_out) && n < 20000);
      check(name, n < 20000, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd_base, pl_base, pulses_before, n;
      logic [7:0] b;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_rd_en", rd_en_out, 0);
      check("rst_clk_oe", ps2_clk_oe_out, 0);
      check("rst_d_oe", ps2_d_oe_out, 0);
      check("rst_act", ps2_tx_act_out, 0);
      check("rst_ack", ack_out, 0);
      check("rst_err", err_out, 0);
      rst = 1'b0;

      // Empty FIFO: nothing happens.
      repeat (200) @(negedge clk);
      check("empty_no_rd_en", rd_en_cyc.size(), 0);
      check("empty_no_lines", oe_active, 0);
      check("empty_idle", ps2_tx_act_out, 0);

      // Reference bytes with an acknowledging device.
      push_tx(8'hF4, K_ACK);
      wait_done("done_f4");
      check("f4_single_rd_en", rd_en_cyc.size(), 1);

      push_tx(8'hED, K_ACK);
      wait_done("done_ed");
      check("ed_clk_low_time", last_clk_run, INH + RTS);

      // Device leaves data high at the ack edge.
      dev_mode = M_NACK;
      push_tx(8'($urandom_range(0, 255)), K_ERR);
      wait_done("done_nack");
      check("nack_idle", ps2_tx_act_out, 0);
      dev_mode = M_ACK;

      // Device never clocks.
      dev_mode = M_SILENT;
      push_tx(8'($urandom_range(0, 255)), K_TO);
      wait_done("done_timeout");
      dev_mode = M_ACK;

      // Reset in the middle of the data bits.
      b = 8'h86;
      dev_falls = 0;
      fifo_q.push_back(b);
      n = 0;
      while (dev_falls < 5 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("rst_reach_bit4", dev_falls >= 5, 1);
      repeat (10) @(negedge clk);
      check("rst_pre_d_oe", ps2_d_oe_out, ((int'(b) >> 4) % 2) == 0);
      pulses_before = pulse_cyc.size();
      rst = 1'b1;
      #1;
      check("rst_mid_clk_oe", ps2_clk_oe_out, 0);
      check("rst_mid_d_oe", ps2_d_oe_out, 0);
      dev_abort = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      dev_abort = 1'b0;
      check("rst_no_pulse", pulse_cyc.size(), pulses_before);
      push_tx(8'($urandom_range(0, 255)), K_ACK);
      wait_done("done_after_rst");

      // Two queued bytes go strictly one after the other.
      rd_base = rd_en_cyc.size();
      pl_base = pulse_cyc.size();
      push_tx(8'($urandom_range(0, 255)), K_ACK);
      push_tx(8'($urandom_range(0, 255)), K_ACK);
      wait_done("done_pair");
      check("pair_rd_en_count", rd_en_cyc.size() - rd_base, 2);
      if (rd_en_cyc.size() >= rd_base + 2 && pulse_cyc.size() > pl_base)
         check("pair_second_after_first", rd_en_cyc[rd_base + 1] > pulse_cyc[pl_base], 1);

      // Random bytes, all queued at once.
      for (int i = 0; i < 4; i++) push_tx(8'($urandom_range(0, 255)), K_ACK);
      wait_done("done_random");

      check("rd_en_only_idle", rd_en_bad, 0);
      check("frames_drained", dev_frames.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, sets the clock-inhibit hold time (100 us at 50 MHz).
REQ-002 Parameter RTS_CYCLES, default 50, sets the data-low setup time before clock release.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000, sets the transfer abort limit, measured from clock release.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 rd_en_out  out  1  FIFO read strobe; data is valid on rd_d_in one cycle later.
REQ-008 rd_d_in  in  8  command byte from the FIFO.
REQ-009 rd_empty_in  in  1  FIFO empty.
REQ-010 ps2_clk_in  in  1  PS/2 clock line level.
REQ-011 ps2_d_in  in  1  PS/2 data line level.
REQ-012 ps2_clk_oe_out  out  1  1 = pull the clock line low; 0 = release it.
REQ-013 ps2_d_oe_out  out  1  1 = pull the data line low; 0 = release it.
REQ-014 ps2_tx_act_out  out  1  high from FETCH until return to IDLE.
REQ-015 ack_out  out  1  one-cycle pulse: the device acknowledged the byte.
REQ-016 err_out  out  1  one-cycle pulse: NACK or timeout.

Function
REQ-017 Filtering: the clock and data lines SHALL each pass through an 8-bit history shift register, newest sample in the LSB.
REQ-018 A falling edge SHALL be detected when the clock history equals 8'hF0; a line counts as high when its history equals 8'hFF.
REQ-019 States SHALL be IDLE, FETCH, LATCH, INHIBIT, RTS, DATA, ACK and WAIT_IDLE.
REQ-020 IDLE: when rd_empty_in=0, assert rd_en_out for exactly one cycle and go to FETCH; rd_en_out SHALL never assert outside IDLE.
REQ-021 FETCH -> LATCH after one cycle; LATCH captures rd_d_in and computes parity = ~^byte (odd parity).
REQ-022 INHIBIT: ps2_clk_oe_out=1 for INHIBIT_CYCLES cycles.
REQ-023 RTS: ps2_clk_oe_out=1 and ps2_d_oe_out=1 (start bit) for RTS_CYCLES cycles.
REQ-024 RTS exit: release the clock, start the timeout counter and enter DATA with the bit index at 0.
REQ-025 DATA: on falling edges 1..8, set ps2_d_oe_out to the inverse of data bit 0..7 (LSB first).
REQ-026 DATA: on falling edge 9, drive parity; on falling edge 10, set ps2_d_oe_out=0 (stop bit) and go to ACK.
REQ-027 ACK: on the next falling edge, sample filtered data: 0 -> ack_out pulse, 1 -> err_out pulse; then go to WAIT_IDLE.
REQ-028 WAIT_IDLE: wait until both the clock and data lines are filtered-high, then go to IDLE.
REQ-029 Timeout: if the counter reaches TIMEOUT_CYCLES in DATA, ACK or WAIT_IDLE, release both lines, pulse err_out and go to IDLE.
REQ-030 Timeout abort SHALL take priority over an edge arriving in the same cycle.
REQ-031 ack_out and err_out SHALL never assert in the same cycle.
REQ-032 Bytes SHALL be sent strictly one at a time; a non-empty FIFO during a transfer has no effect until IDLE.
REQ-033 Counter widths SHALL be sized by $clog2 of their parameter; no counter wraps.

Reset
REQ-034 rst SHALL immediately force state IDLE; all outputs 0; counters 0; history registers 8'hFF.
REQ-035 Reset mid-transfer SHALL release both lines in the same cycle; no ack_out or err_out pulse is generated.

Structure
REQ-036 The state encoding and default timing constants SHALL live in a shared package, ps2_pkg.
REQ-037 Line filtering and edge detection SHALL be a sub-module, ps2_line_filter, reusable by the PS/2 receiver.

Verification
REQ-038 FIFO holds 0xF4, device model acks -> rd_en_out once; DATA bits 0,0,1,0,1,1,1,1; parity 0; stop released; ack_out one pulse.
REQ-039 FIFO holds 0xED -> bits 1,0,1,1,0,1,1,1; parity 1; ack_out pulse; ps2_clk_oe_out low time is INHIBIT_CYCLES+RTS_CYCLES.
REQ-040 Device holds data high at the ACK edge -> err_out one pulse, no ack_out, return to IDLE.
REQ-041 Device never clocks -> err_out exactly TIMEOUT_CYCLES after clock release; both oe outputs 0.
REQ-042 rst asserted at bit 4 -> both oe outputs 0 the same cycle, no pulses; the next FIFO byte is sent cleanly after reset.
REQ-043 Two queued bytes -> the second rd_en_out occurs only after WAIT_IDLE completes; rd_empty_in=1 -> no line activity.
